// File: rtl/decoder_pkg.sv
// Shared definitions for the registered 2-to-4 one-hot decoder.
//   SEL_W       : width of the binary select
//   OUT_W       : width of the one-hot decode
//   onehot4_t   : type of the one-hot decode vector
//   ONEHOT_IDLE : decode with no active bit (active-high sense)
package decoder_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  typedef logic [OUT_W-1:0] onehot4_t;

  localparam onehot4_t ONEHOT_IDLE = 4'b0000;

endpackage : decoder_pkg

// File: rtl/decoder_2to4_core.sv
// Combinational 2-to-4 one-hot decode.
//   i   in  SEL_W  binary select
//   o   out OUT_W  active-high one-hot decode of i (ONEHOT_IDLE if i is not a clean code)
//   hit out 1      high when i decoded to a legal one-hot pattern
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic [SEL_W-1:0] i,
  output onehot4_t         o,
  output logic             hit
);

  // Explicit case rather than a shift: an unknown select falls to the default
  // branch, so the output can never come out multi-hot.
  always_comb begin
    o   = ONEHOT_IDLE;
    hit = 1'b0;
    case (i)
      2'b00: begin o = 4'b0001; hit = 1'b1; end
      2'b01: begin o = 4'b0010; hit = 1'b1; end
      2'b10: begin o = 4'b0100; hit = 1'b1; end
      2'b11: begin o = 4'b1000; hit = 1'b1; end
      default: begin
        o   = ONEHOT_IDLE;
        hit = 1'b0;
      end
    endcase
  end

endmodule : decoder_2to4_core

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder, one cycle of latency.
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-high reset
//   en       in  1      decode enable; en=0 drives the inactive pattern
//   i        in  SEL_W  binary select
//   o        out OUT_W  registered decode (inverted when OUT_ACTIVE_LOW=1)
//   o_valid  out 1      o holds a decode of an enabled, clean select
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] i,
  output onehot4_t         o,
  output logic             o_valid
);

  // XOR mask applied to the whole vector: all ones inverts the sense.
  localparam onehot4_t POL_MASK = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam onehot4_t IDLE_OUT = ONEHOT_IDLE ^ POL_MASK;

  onehot4_t dec;
  logic     hit;
  logic     take;

  decoder_2to4_core u_core (
    .i   (i),
    .o   (dec),
    .hit (hit)
  );

  // An enabled but unclean select is treated like en=0.
  assign take = en & hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o       <= IDLE_OUT;
      o_valid <= 1'b0;
    end else if (take) begin
      o       <= dec ^ POL_MASK;
      o_valid <= 1'b1;
    end else begin
      o       <= IDLE_OUT;
      o_valid <= 1'b0;
    end
  end

endmodule : decoder_2to4

// File: tb/tb_decoder_2to4.sv
// Directed and randomised checks for decoder_2to4, both output polarities.
module tb_decoder_2to4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] i   = 2'b00;
  logic [3:0] o_hi;
  logic       v_hi;
  logic [3:0] o_lo;
  logic       v_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i       (i),
    .o       (o_hi),
    .o_valid (v_hi)
  );

  decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i       (i),
    .o       (o_lo),
    .o_valid (v_lo)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Checks all outputs of both instances against an active-high expected decode.
  task automatic check_all(input string tag, input logic [3:0] exp_o, input logic exp_v);
    check_val({tag, ".o"},      {4'b0, o_hi}, {4'b0, exp_o});
    check_val({tag, ".v"},      {7'b0, v_hi}, {7'b0, exp_v});
    check_val({tag, ".o_al"},   {4'b0, o_lo}, {4'b0, ~exp_o});
    check_val({tag, ".v_al"},   {7'b0, v_lo}, {7'b0, exp_v});
  endtask

  task automatic step(input logic e, input logic [1:0] s);
    en = e;
    i  = s;
    @(negedge clk);
  endtask

  logic [3:0] sweep_exp [4];
  logic [3:0] ref_o;
  logic       ref_v;

  initial begin
    sweep_exp[0] = 4'b0001;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100;
    sweep_exp[3] = 4'b1000;

    // Reset with no clock edge: outputs must follow at once.
    #2 rst = 1'b1;
    #1;
    check_all("rst_async", 4'b0000, 1'b0);
    check_val("rst_async_lo_lit", {4'b0, o_lo}, 8'b0000_1111);
    en = 1'b1;
    i  = 2'b11;
    repeat (3) @(negedge clk);
    check_all("rst_hold", 4'b0000, 1'b0);
    rst = 1'b0;

    // Sweep all selects on successive edges.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k[1:0]);
      check_all($sformatf("sweep%0d", k), sweep_exp[k], 1'b1);
    end
    check_val("pol_i01_pre", 8'd0, 8'd0 ^ 8'd0 ^ {7'b0, 1'b0});
    n_tests--;

    // Polarity literal check for the active-low instance.
    step(1'b1, 2'b01);
    check_val("pol_i01", {4'b0, o_lo}, 8'b0000_1101);

    // Enable gating: no hold of the last decode.
    step(1'b0, 2'b10);
    check_all("en_off", 4'b0000, 1'b0);
    check_val("pol_en_off", {4'b0, o_lo}, 8'b0000_1111);
    step(1'b1, 2'b10);
    check_all("en_on", 4'b0100, 1'b1);
    step(1'b1, 2'b10);
    check_all("same_sel", 4'b0100, 1'b1);

    // Mid-stream reset pulsed between edges.
    step(1'b1, 2'b01);
    check_all("mid_pre", 4'b0010, 1'b1);
    i = 2'b11;
    #2 rst = 1'b1;
    #1;
    check_all("mid_rst", 4'b0000, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all("mid_post", 4'b1000, 1'b1);

    // Random stream against a shift-based reference, plus the one-hot invariant.
    for (int n = 0; n < 1000; n++) begin
      logic       e;
      logic [1:0] s;
      e = 1'($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      step(e, s);
      ref_o = e ? (4'b0001 << s) : 4'b0000;
      ref_v = e;
      check_all("rand", ref_o, ref_v);
      check_val("inv_hi", 8'($countones(o_hi)), v_hi ? 8'd1 : 8'd0);
      check_val("inv_lo", 8'($countones(~o_lo)), v_lo ? 8'd1 : 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decoder_2to4
